// File: rtl/sched_pkg.sv
// Shared schedule encodings: master/slave FSM codes, store channel indices
// and the store-sequencer state type.
package sched_pkg;

  localparam int MAST_FSM_BITS = 3;
  localparam logic [MAST_FSM_BITS-1:0] M_IDLE  = 3'd0;
  localparam logic [MAST_FSM_BITS-1:0] M_LEFT  = 3'd1;
  localparam logic [MAST_FSM_BITS-1:0] M_BASE  = 3'd2;
  localparam logic [MAST_FSM_BITS-1:0] M_RIGHT = 3'd3;
  localparam logic [MAST_FSM_BITS-1:0] M_FSLD  = 3'd7;

  localparam int SLV_FSM_BITS = 2;
  localparam logic [SLV_FSM_BITS-1:0] S_IDLE = 2'd0;
  localparam logic [SLV_FSM_BITS-1:0] S_TOP  = 2'd1;
  localparam logic [SLV_FSM_BITS-1:0] S_MID  = 2'd2;
  localparam logic [SLV_FSM_BITS-1:0] S_BOTT = 2'd3;

  localparam int CH_KER  = 0;
  localparam int CH_BIAS = 1;
  localparam int CH_IF   = 2;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_SEL,
    SEQ_START,
    SEQ_WAIT,
    SEQ_END
  } seq_state_e;

endpackage

// File: rtl/sched_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest requesting channel
// plus a valid bit when any request is present.
module sched_prio_enc #(
  parameter int NUM_CH = 3,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  output logic [CH_W-1:0]   idx,
  output logic              vld
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    vld = |req;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (req[i-1]) idx = CH_W'(i - 1);
    end
  end

endmodule

// File: rtl/sched_store_seq.sv
// Store-module sequencer: runs the masked channels one at a time, lowest
// index first, on FSLD entry or a load request, with timeout and abort.
module sched_store_seq
  import sched_pkg::*;
#(
  parameter int                       NUM_CH        = 3,
  parameter int                       MAST_FSM_BITS = 3,
  parameter logic [MAST_FSM_BITS-1:0] FSLD_CODE     = MAST_FSM_BITS'(7),
  parameter int                       TIMEOUT_CYC   = 1024,
  parameter int                       CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [MAST_FSM_BITS-1:0] mast_curr_state,
  input  logic [NUM_CH-1:0]        ch_en_mask,
  input  logic                     load_req,
  input  logic [NUM_CH-1:0]        store_busy,
  input  logic [NUM_CH-1:0]        store_done,
  output logic [NUM_CH-1:0]        start_store,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     seq_busy,
  output logic                     flag_seq_end,
  output logic                     flag_fsld_end,
  output logic                     timeout_err
);

  localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);

  seq_state_e                 state_q, state_d;
  logic [MAST_FSM_BITS-1:0]   mast_prev;
  logic [NUM_CH-1:0]          rem;
  logic                       fsld_src;
  logic [TO_W-1:0]            to_cnt;
  logic [CH_W-1:0]            enc_idx;
  logic                       enc_vld;
  logic                       in_fsld, trig_fsld, abort;
  logic                       go, sel_load, fire, ch_done, to_hit;

  sched_prio_enc #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_prio_enc (
    .req (rem),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  assign in_fsld   = (mast_curr_state == FSLD_CODE);
  assign trig_fsld = in_fsld && (mast_prev != FSLD_CODE);
  assign abort     = fsld_src && !in_fsld &&
                     (state_q inside {SEQ_SEL, SEQ_START, SEQ_WAIT});

  always_comb begin
    state_d  = state_q;
    go       = 1'b0;
    sel_load = 1'b0;
    fire     = 1'b0;
    ch_done  = 1'b0;
    to_hit   = 1'b0;
    if (abort) begin
      state_d = SEQ_IDLE;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (trig_fsld || load_req) begin
            go      = 1'b1;
            state_d = SEQ_SEL;
          end
        end
        SEQ_SEL: begin
          if (!enc_vld) begin
            state_d = SEQ_END;
          end else begin
            sel_load = 1'b1;
            state_d  = SEQ_START;
          end
        end
        SEQ_START: begin
          if (!store_busy[cur_ch] && !store_done[cur_ch]) begin
            fire    = 1'b1;
            state_d = SEQ_WAIT;
          end
        end
        SEQ_WAIT: begin
          if (store_done[cur_ch]) begin
            ch_done = 1'b1;
            state_d = SEQ_SEL;
          end else if (TO_EN && (to_cnt == TO_LAST)) begin
            to_hit  = 1'b1;
            state_d = SEQ_IDLE;
          end
        end
        SEQ_END:  state_d = SEQ_IDLE;
        default:  state_d = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SEQ_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mast_prev   <= '0;
      rem         <= '0;
      fsld_src    <= 1'b0;
      to_cnt      <= '0;
      cur_ch      <= '0;
      start_store <= '0;
      timeout_err <= 1'b0;
    end else begin
      mast_prev   <= mast_curr_state;
      start_store <= '0;
      if (go) begin
        rem         <= ch_en_mask;
        fsld_src    <= trig_fsld;
        timeout_err <= 1'b0;
      end
      if (sel_load) cur_ch <= enc_idx;
      if (fire)     start_store <= NUM_CH'(1) << cur_ch;
      if (ch_done)  rem[cur_ch] <= 1'b0;
      // Counter only runs while staying in WAIT, so each channel starts from zero.
      if ((state_q == SEQ_WAIT) && (state_d == SEQ_WAIT)) to_cnt <= to_cnt + TO_W'(1);
      else                                                to_cnt <= '0;
      if (to_hit)   timeout_err <= 1'b1;
    end
  end

  assign seq_busy      = (state_q != SEQ_IDLE);
  assign flag_seq_end  = (state_q == SEQ_END);
  assign flag_fsld_end = (state_q == SEQ_END) && fsld_src && in_fsld;

endmodule

// File: tb/tb_sched_store_seq.sv
// Directed bench for sched_store_seq: expected start/flag events are queued
// with their cycle and matched as the sequencer produces them.
module tb_sched_store_seq;
  import sched_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] mast;
  logic [2:0] mask;
  logic       load_req;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] start_store;
  logic [1:0] cur_ch;
  logic       seq_busy, flag_seq_end, flag_fsld_end, timeout_err;

  always #5 clk = ~clk;

  sched_store_seq #(
    .NUM_CH        (3),
    .MAST_FSM_BITS (3),
    .FSLD_CODE     (M_FSLD),
    .TIMEOUT_CYC   (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mast_curr_state (mast),
    .ch_en_mask      (mask),
    .load_req        (load_req),
    .store_busy      (busy),
    .store_done      (done),
    .start_store     (start_store),
    .cur_ch          (cur_ch),
    .seq_busy        (seq_busy),
    .flag_seq_end    (flag_seq_end),
    .flag_fsld_end   (flag_fsld_end),
    .timeout_err     (timeout_err)
  );

  typedef struct {
    logic [4:0] val;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] st, input logic se, input logic fe, input int c);
    ev_t e;
    e.val = {st, se, fe};
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic sample();
    logic [4:0] obs;
    ev_t        e;
    obs = {start_store, flag_seq_end, flag_fsld_end};
    check("start_onehot", 32'($countones(start_store) <= 1), 1);
    if (obs != 5'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_evt", 32'(obs), 0);
      end else begin
        e = sb.pop_front();
        check("evt_val", 32'(obs), 32'(e.val));
        check("evt_cyc", cyc, e.cyc);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sb_done(input string tag);
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    reset = 1'b1; mast = M_IDLE; mask = '0; load_req = 1'b0; busy = '0; done = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_start", 32'(start_store), 0);
    check("rst_busy", 32'(seq_busy), 0);
    check("rst_flags", 32'({flag_seq_end, flag_fsld_end, timeout_err}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // FSLD sequence over all three channels
    cyc = 0; mast = M_FSLD; mask = 3'b111;
    expect_ev(3'b001, 1'b0, 1'b0, 3);
    expect_ev(3'b010, 1'b0, 1'b0, 13);
    expect_ev(3'b100, 1'b0, 1'b0, 18);
    expect_ev(3'b000, 1'b1, 1'b1, 22);
    repeat (26) begin
      if (cyc == 1) mask = '0;
      done = (cyc == 10) ? 3'b001 : (cyc == 15) ? 3'b010 : (cyc == 20) ? 3'b100 : 3'b000;
      if (cyc == 14) check("fsld_cur_ch", 32'(cur_ch), 1);
      if (cyc == 21) check("fsld_busy_sel", 32'(seq_busy), 1);
      step();
    end
    check("fsld_idle", 32'(seq_busy), 0);
    sb_done("fsld_sb_empty");
    mast = M_IDLE;
    repeat (3) step();

    // load_req, mask 101, channel 2 busy until cycle 8
    cyc = 0; mast = M_BASE; mask = 3'b101;
    expect_ev(3'b001, 1'b0, 1'b0, 3);
    expect_ev(3'b100, 1'b0, 1'b0, 9);
    expect_ev(3'b000, 1'b1, 1'b0, 13);
    repeat (18) begin
      load_req = (cyc == 0);
      busy = (cyc < 8) ? 3'b100 : 3'b000;
      done = (cyc == 5) ? 3'b001 : (cyc == 11) ? 3'b100 : 3'b000;
      if (cyc == 8) begin
        check("busy_cur_ch", 32'(cur_ch), 2);
        check("busy_held", 32'(start_store), 0);
      end
      step();
    end
    sb_done("busy_sb_empty");

    // zero mask: flags in cycle 2, no starts
    cyc = 0; mask = 3'b000;
    expect_ev(3'b000, 1'b1, 1'b0, 2);
    repeat (6) begin
      load_req = (cyc == 0);
      step();
    end
    sb_done("zero_sb_empty");

    // timeout on channel 0, then cleared by the next request
    cyc = 0; mask = 3'b001;
    expect_ev(3'b001, 1'b0, 1'b0, 3);
    repeat (24) begin
      load_req = (cyc == 0);
      if (cyc == 18) begin
        check("to_err_early", 32'(timeout_err), 0);
        check("to_busy_18", 32'(seq_busy), 1);
      end
      if (cyc == 19) begin
        check("to_err_set", 32'(timeout_err), 1);
        check("to_idle_19", 32'(seq_busy), 0);
      end
      step();
    end
    sb_done("to_sb_empty");
    cyc = 0;
    expect_ev(3'b001, 1'b0, 1'b0, 3);
    expect_ev(3'b000, 1'b1, 1'b0, 7);
    repeat (10) begin
      load_req = (cyc == 0);
      done = (cyc == 5) ? 3'b001 : 3'b000;
      if (cyc == 0) check("to_err_sticky", 32'(timeout_err), 1);
      if (cyc == 1) check("to_err_clear", 32'(timeout_err), 0);
      step();
    end
    sb_done("toclr_sb_empty");

    // master leaves FSLD while waiting on channel 1
    cyc = 0; mast = M_FSLD; mask = 3'b111;
    expect_ev(3'b001, 1'b0, 1'b0, 3);
    expect_ev(3'b010, 1'b0, 1'b0, 13);
    repeat (30) begin
      if (cyc >= 14) mast = M_BASE;
      done = (cyc == 10) ? 3'b001 : 3'b000;
      if (cyc == 14) check("abort_busy_14", 32'(seq_busy), 1);
      if (cyc == 15) check("abort_idle_15", 32'(seq_busy), 0);
      step();
    end
    check("abort_no_err", 32'(timeout_err), 0);
    sb_done("abort_sb_empty");

    // load_req together with the FSLD edge, further requests while busy
    cyc = 0; mast = M_FSLD; mask = 3'b011;
    expect_ev(3'b001, 1'b0, 1'b0, 3);
    expect_ev(3'b010, 1'b0, 1'b0, 9);
    expect_ev(3'b000, 1'b1, 1'b1, 13);
    repeat (22) begin
      load_req = (cyc == 0) || (cyc == 4) || (cyc == 12) || (cyc == 13);
      done = (cyc == 6) ? 3'b001 : (cyc == 11) ? 3'b010 : 3'b000;
      step();
    end
    check("coll_idle", 32'(seq_busy), 0);
    sb_done("coll_sb_empty");
    mast = M_BASE;
    repeat (3) step();

    // asynchronous reset while a start pulse is out
    cyc = 0; mask = 3'b100;
    repeat (3) begin
      load_req = (cyc == 0);
      step();
    end
    check("rstw_start_pend", 32'(start_store), 32'(3'b100));
    check("rstw_cur_ch", 32'(cur_ch), 2);
    reset = 1'b0;
    #1;
    check("rstw_start", 32'(start_store), 0);
    check("rstw_cur_ch0", 32'(cur_ch), 0);
    check("rstw_busy", 32'(seq_busy), 0);
    check("rstw_flags", 32'({flag_seq_end, flag_fsld_end, timeout_err}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rstw_idle_rel", 32'(seq_busy), 0);
    repeat (6) step();
    check("rstw_idle_after", 32'(seq_busy), 0);
    sb_done("rstw_sb_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
